// File: rtl/sort_unit_gather_pkg.sv
// sort_unit_gather_pkg
//   Shared types for the sort-unit gather block.
//   - idx_e  : accumulation state, i.e. the next free slot of the pending group
//   - NSLOTS : number of elements in one sort-unit group
package sort_unit_gather_pkg;

  localparam int unsigned NSLOTS = 4;

  typedef enum logic [1:0] {
    IDX_0 = 2'd0,
    IDX_1 = 2'd1,
    IDX_2 = 2'd2,
    IDX_3 = 2'd3
  } idx_e;

endpackage

// File: rtl/sort_unit_gather_slots.sv
// sort_unit_gather_slots
//   Four-entry write-indexed register file holding the partial group.
//   Ports:
//     clk, reset          : clock, synchronous active-low reset (clears all slots)
//     wr_en, wr_idx       : write strobe and slot index
//     wr_data             : element written into slots[wr_idx]
//     slots               : current contents of all four slots
module sort_unit_gather_slots
  import sort_unit_gather_pkg::*;
#(
  parameter int unsigned p_nbits = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [1:0]         wr_idx,
  input  logic [p_nbits-1:0] wr_data,
  output logic [p_nbits-1:0] slots [NSLOTS]
);

  // Slot storage: cleared on reset, otherwise a single indexed write per cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NSLOTS); i++) begin
        slots[i] <= '0;
      end
    end else if (wr_en) begin
      slots[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/sort_unit_gather.sv
// sort_unit_gather
//   Packs a serial val/rdy element stream into groups of four for a sort unit.
//   Short groups (in_last or flush) are padded with all ones so real elements
//   sort ahead of the padding. A completed group is presented for exactly one
//   cycle with out_val; outputs read zero whenever out_val is low.
//   Ports:
//     clk, reset            : clock, synchronous active-low reset
//     in_val/in_rdy/in_msg  : input element handshake and data
//     in_last               : element closes the current group
//     flush                 : emit the pending partial group without a new element
//     out_val, out0..out3   : group pulse and slots (out0 = first arrival)
//     out_nreal             : number of real elements in the group (1..4)
//     ngroups               : groups emitted since reset, wrapping
module sort_unit_gather
  import sort_unit_gather_pkg::*;
#(
  parameter int unsigned p_nbits     = 8,
  parameter int unsigned p_cnt_nbits = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [p_nbits-1:0]     in_msg,
  input  logic                   in_last,
  input  logic                   flush,
  output logic                   out_val,
  output logic [p_nbits-1:0]     out0,
  output logic [p_nbits-1:0]     out1,
  output logic [p_nbits-1:0]     out2,
  output logic [p_nbits-1:0]     out3,
  output logic [2:0]             out_nreal,
  output logic [p_cnt_nbits-1:0] ngroups
);

  localparam logic [p_nbits-1:0] PAD = {p_nbits{1'b1}};

  idx_e                   state;
  idx_e                   state_next;
  logic                   xfer;
  logic                   emit;
  logic                   slot_wr;
  logic [p_nbits-1:0]     slots   [NSLOTS];
  logic [p_nbits-1:0]     grp     [NSLOTS];
  logic [2:0]             grp_nreal;
  logic [p_nbits-1:0]     out_q   [NSLOTS];
  logic [2:0]             nreal_q;
  logic                   val_q;
  logic [p_cnt_nbits-1:0] cnt_q;

  // The downstream never stalls, so input readiness depends on reset alone.
  assign in_rdy = reset;
  assign xfer   = in_val && in_rdy;

  sort_unit_gather_slots #(
    .p_nbits (p_nbits)
  ) u_slots (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (slot_wr),
    .wr_idx  (state),
    .wr_data (in_msg),
    .slots   (slots)
  );

  // Accumulation state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDX_0;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A completing element (slot 3, in_last or flush) bypasses
  // the slot file and goes straight into the output group, so only
  // non-completing transfers write a slot.
  always_comb begin
    state_next = state;
    slot_wr    = 1'b0;
    emit       = 1'b0;
    if (xfer) begin
      if (state == IDX_3 || in_last || flush) begin
        emit       = 1'b1;
        state_next = IDX_0;
      end else begin
        slot_wr    = 1'b1;
        state_next = idx_e'(state + 2'd1);
      end
    end else if (flush && state != IDX_0) begin
      emit       = 1'b1;
      state_next = IDX_0;
    end
  end

  // Group assembly: stored slots below idx, the incoming element at idx when
  // there is a transfer, padding everywhere above.
  always_comb begin
    for (int i = 0; i < int'(NSLOTS); i++) begin
      if (i < int'(state)) begin
        grp[i] = slots[i];
      end else if (i == int'(state) && xfer) begin
        grp[i] = in_msg;
      end else begin
        grp[i] = PAD;
      end
    end
    grp_nreal = {1'b0, state} + {2'b00, xfer};
  end

  // Output group registers, kept apart from the slots so the next group can
  // accumulate while this one is presented.
  always_ff @(posedge clk) begin
    if (!reset) begin
      val_q   <= 1'b0;
      nreal_q <= 3'd0;
      cnt_q   <= '0;
      for (int i = 0; i < int'(NSLOTS); i++) begin
        out_q[i] <= '0;
      end
    end else begin
      val_q <= emit;
      if (emit) begin
        out_q   <= grp;
        nreal_q <= grp_nreal;
        cnt_q   <= cnt_q + p_cnt_nbits'(1);
      end
    end
  end

  assign out_val   = val_q;
  assign out0      = val_q ? out_q[0] : '0;
  assign out1      = val_q ? out_q[1] : '0;
  assign out2      = val_q ? out_q[2] : '0;
  assign out3      = val_q ? out_q[3] : '0;
  assign out_nreal = val_q ? nreal_q : 3'd0;
  assign ngroups   = cnt_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset) begin
      assert (!$isunknown({in_val, flush, out_val}));
      assert (!out_val || (out_nreal >= 3'd1 && out_nreal <= 3'd4));
    end
  end

  function automatic string line_trace();
    return $sformatf("%b%b %h%s | %0d [%h %h %h %h] | %s %h %h %h %h n%0d",
                     in_val, in_rdy, in_msg, in_last ? "L" : " ",
                     state, slots[0], slots[1], slots[2], slots[3],
                     out_val ? "V" : ".", out0, out1, out2, out3, out_nreal);
  endfunction
`endif

endmodule

// File: tb/tb_sort_unit_gather.sv
// tb_sort_unit_gather
//   Directed scoreboard bench. Stimulus pushes hand-computed groups together
//   with the cycle they must appear in; a negedge monitor pops and compares.
//   A second instance with a 2-bit group counter sees the same stream and is
//   checked for counter wrap.
module tb_sort_unit_gather;

  logic        clk     = 1'b0;
  logic        reset   = 1'b0;
  logic        in_val  = 1'b0;
  logic        in_last = 1'b0;
  logic        flush   = 1'b0;
  logic [7:0]  in_msg  = 8'h00;
  logic        in_rdy, in_rdy2;
  logic        out_val, out_val2;
  logic [7:0]  out0, out1, out2, out3;
  logic [7:0]  o2_0, o2_1, o2_2, o2_3;
  logic [2:0]  out_nreal, out_nreal2;
  logic [15:0] ngroups;
  logic [1:0]  ngroups2;

  typedef struct {
    logic [7:0]  o0, o1, o2, o3;
    logic [2:0]  nreal;
    logic [15:0] ng;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  sort_unit_gather #(.p_nbits(8), .p_cnt_nbits(16)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .in_last(in_last), .flush(flush), .out_val(out_val), .out0(out0), .out1(out1),
    .out2(out2), .out3(out3), .out_nreal(out_nreal), .ngroups(ngroups)
  );

  sort_unit_gather #(.p_nbits(8), .p_cnt_nbits(2)) dut_wrap (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy2), .in_msg(in_msg),
    .in_last(in_last), .flush(flush), .out_val(out_val2), .out0(o2_0), .out1(o2_1),
    .out2(o2_2), .out3(o2_3), .out_nreal(out_nreal2), .ngroups(ngroups2)
  );

  always #5 clk = ~clk;

  // Cycle counter used to check pulse timing.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs just after the active edge.
  task automatic applyStimulus(input logic v, input logic [7:0] msg, input logic last,
                               input logic fl, input logic rst);
    @(posedge clk);
    #1;
    reset   = rst;
    in_val  = v;
    in_msg  = msg;
    in_last = last;
    flush   = fl;
  endtask

  // Expect a group from the stimulus just driven: it completes at the next
  // edge, so the pulse is seen while cyc equals the current value plus one.
  task automatic expectGroup(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                             input logic [7:0] d, input logic [2:0] n, input logic [15:0] ng);
    exp_t e;
    e.o0 = a; e.o1 = b; e.o2 = c; e.o3 = d;
    e.nreal = n; e.ng = ng; e.cyc = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic sendElem(input logic [7:0] msg, input logic last);
    applyStimulus(1'b1, msg, last, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compare every presented group against the scoreboard head, and
  // check masked outputs plus missing pulses in idle cycles.
  always @(negedge clk) begin
    if (out_val === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("pulse_cycle", cyc, mon_e.cyc);
        checkOutput("group_data", {out0, out1, out2, out3}, {mon_e.o0, mon_e.o1, mon_e.o2, mon_e.o3});
        checkOutput("out_nreal", {29'd0, out_nreal}, {29'd0, mon_e.nreal});
        checkOutput("ngroups", {16'd0, ngroups}, {16'd0, mon_e.ng});
        checkOutput("ngroups_wrap", {30'd0, ngroups2}, {30'd0, mon_e.ng[1:0]});
      end
    end else begin
      checkOutput("idle_data", {out0, out1, out2, out3}, 32'd0);
      checkOutput("idle_nreal", {29'd0, out_nreal}, 32'd0);
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        checkOutput("pulse_missing", 32'd0, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    $display("[TB] start");
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_in_rdy", {31'd0, in_rdy}, 32'd0);
    checkOutput("reset_out_val", {31'd0, out_val}, 32'd0);
    checkOutput("reset_ngroups", {16'd0, ngroups}, 32'd0);
    idle(1);
    checkOutput("run_in_rdy", {31'd0, in_rdy}, 32'd1);

    // Full group
    sendElem(8'h04, 1'b0); sendElem(8'h03, 1'b0); sendElem(8'h02, 1'b0);
    sendElem(8'h01, 1'b0); expectGroup(8'h04, 8'h03, 8'h02, 8'h01, 3'd4, 16'd1);
    idle(2);

    // Short group via in_last, then a full group from slot 0
    sendElem(8'h0a, 1'b0);
    sendElem(8'h0b, 1'b1); expectGroup(8'h0a, 8'h0b, 8'hff, 8'hff, 3'd2, 16'd2);
    sendElem(8'h01, 1'b0); sendElem(8'h02, 1'b0); sendElem(8'h03, 1'b0);
    sendElem(8'h04, 1'b0); expectGroup(8'h01, 8'h02, 8'h03, 8'h04, 3'd4, 16'd3);
    idle(1);

    // Flush of a partial group, then a flush with nothing pending
    sendElem(8'h05, 1'b0);
    idle(3);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1); expectGroup(8'h05, 8'hff, 8'hff, 8'hff, 3'd1, 16'd4);
    idle(1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Back-to-back full groups
    for (int i = 1; i <= 8; i++) begin
      sendElem(8'(i), 1'b0);
      if (i == 4) expectGroup(8'h01, 8'h02, 8'h03, 8'h04, 3'd4, 16'd5);
      if (i == 8) expectGroup(8'h05, 8'h06, 8'h07, 8'h08, 3'd4, 16'd6);
    end
    // Back-to-back single-element groups
    sendElem(8'h11, 1'b1); expectGroup(8'h11, 8'hff, 8'hff, 8'hff, 3'd1, 16'd7);
    sendElem(8'h22, 1'b1); expectGroup(8'h22, 8'hff, 8'hff, 8'hff, 3'd1, 16'd8);
    sendElem(8'h33, 1'b1); expectGroup(8'h33, 8'hff, 8'hff, 8'hff, 3'd1, 16'd9);
    idle(2);

    // Reset mid-group discards the partial group
    sendElem(8'h01, 1'b0); sendElem(8'h02, 1'b0);
    applyStimulus(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    checkOutput("midreset_in_rdy", {31'd0, in_rdy}, 32'd0);
    applyStimulus(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    checkOutput("midreset_out_val", {31'd0, out_val}, 32'd0);
    sendElem(8'h07, 1'b1); expectGroup(8'h07, 8'hff, 8'hff, 8'hff, 3'd1, 16'd1);

    // Flush together with a transfer closes the group like in_last
    sendElem(8'h20, 1'b0);
    applyStimulus(1'b1, 8'h21, 1'b0, 1'b1, 1'b1); expectGroup(8'h20, 8'h21, 8'hff, 8'hff, 3'd2, 16'd2);
    sendElem(8'h30, 1'b0); sendElem(8'h31, 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b0, 1'b1, 1'b1); expectGroup(8'h30, 8'h31, 8'h32, 8'hff, 3'd3, 16'd3);

    // All-ones element and counter wrap on the 2-bit instance
    sendElem(8'hff, 1'b1); expectGroup(8'hff, 8'hff, 8'hff, 8'hff, 3'd1, 16'd4);
    sendElem(8'h09, 1'b1); expectGroup(8'h09, 8'hff, 8'hff, 8'hff, 3'd1, 16'd5);
    idle(5);

    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sort_unit_gather.md
Name: sort_unit_gather

Overview:
- Upstream feeder for the four-element sorting units.
- Accepts a serial val/rdy stream of p_nbits elements, packs them in arrival order into groups of four, and drives a single-cycle out_val pulse with out0..out3.
- Supports short groups via in_last or flush; unused slots are padded with p_nbits'1 so real elements sort ahead of the padding.
- Outputs connect directly to a sort unit's in_val/in0..in3; the sort unit applies no backpressure, so the output side has no ready.

Parameters:
- p_nbits, 8, element width in bits
- p_cnt_nbits, 16, width of the completed-group counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_val  in  1  input element valid
- in_rdy  out  1  input ready; transfer occurs when in_val && in_rdy
- in_msg  in  p_nbits  input element
- in_last  in  1  qualifies in_msg as the final element of a group; sampled only on transfer
- flush  in  1  emit the pending partial group without a new element
- out_val  out  1  group valid, one-cycle pulse
- out0  out  p_nbits  slot 0 (first-arrived element)
- out1  out  p_nbits  slot 1
- out2  out  p_nbits  slot 2
- out3  out  p_nbits  slot 3
- out_nreal  out  3  number of real (non-pad) elements in the group, 1..4
- ngroups  out  p_cnt_nbits  count of groups emitted since reset, wraps modulo 2^p_cnt_nbits

Behaviour:
- Reset (reset==0 at posedge):
  - idx=0, partial slots cleared, out_val=0, ngroups=0.
  - Any partial group is discarded.
  - in_rdy=0 while reset==0; in_rdy=1 otherwise (always accepts). in_rdy is combinational on reset only.
- Accumulate state: idx in 0..3 is the next free slot. This is the FSM state; the group-valid register is the only other state.
- Transfer with idx<3 and in_last=0:
  - slot[idx] <= in_msg, idx <= idx+1
  - no output event
- Transfer with idx==3, or with in_last=1 (any idx):
  - The group is slot[0..idx-1], in_msg at slot[idx], and slots idx+1..3 = all ones.
  - This group is loaded into the output registers at the same edge; out_val=1 the next cycle.
  - out_nreal=idx+1, idx <= 0, ngroups increments.
- flush=1 without a transfer:
  - idx>0: emit slot[0..idx-1] with the remaining slots padded to all ones; out_nreal=idx; idx <= 0.
  - idx==0: ignored; no pulse, no count.
- flush=1 with a transfer: treated exactly as a transfer with in_last=1.
- Latency and throughput:
  - out_val asserts exactly one cycle after the completing transfer or flush edge, and deasserts the following cycle unless another group completes.
  - Back-to-back groups are allowed: a 4-element group every 4 cycles, or a 1-element last-group every cycle, with out_val held high across consecutive completions.
- Output registers are separate from the accumulation slots, so accumulation of the next group proceeds during the out_val cycle.
- When out_val=0: out0..out3 and out_nreal read 0. Outputs are masked and never X.
- ngroups wraps from 2^p_cnt_nbits-1 to 0 with no flag.
- An element valued all ones is legal and indistinguishable from padding in the data; out_nreal disambiguates.
- Reset mid-group: the partial group is lost, no pulse is produced, and the first transfer after reset lands in slot 0.
- Assertions (non-synthesis), checked when reset==1:
  - in_val, flush and out_val are never X.
  - out_nreal is in 1..4 whenever out_val=1.
- Line trace:
  - input: val/rdy/msg with an L marker for last
  - idx and partial slots
  - output group with nreal

Decomposition:
- Local parameter: PAD = {p_nbits{1'b1}}. No shared package is needed; p_nbits flows by parameter.
- Optional sub-module sort_unit_gather_slots: four-entry write-indexed register file with clear. Reuse the existing Reg/ResetReg library cells for the output and valid registers.

Test Plan:
- Full group: 4 transfers 0x04,0x03,0x02,0x01 on consecutive cycles -> one cycle after the 4th: out_val=1, out={04,03,02,01}, out_nreal=4, ngroups=1; next cycle out_val=0, outputs 0.
- Short group via last: 0x0a, then 0x0b with in_last=1 -> out={0a,0b,ff,ff}, out_nreal=2; following 4-element group 1,2,3,4 starts at slot 0.
- Flush: 0x05 only, idle 3 cycles, flush pulse -> out={05,ff,ff,ff}, out_nreal=1. A second flush with idx==0 produces no pulse and leaves ngroups unchanged.
- Back-to-back:
  - 8 consecutive transfers 1..8 -> pulses at cycles 5 and 9 with {1,2,3,4} and {5,6,7,8}.
  - 3 consecutive last-elements 0x11,0x22,0x33 -> out_val high 3 cycles, out_nreal=1 each.
- Reset mid-group: 0x01,0x02 then reset=0 for 2 cycles (in_rdy=0, out_val=0), then 0x07 with in_last=1 -> out={07,ff,ff,ff}, out_nreal=1, ngroups=1.
- End to end: drive a sort unit with p_cnt_nbits=2 and 5 single-element last groups -> ngroups sequence 1,2,3,0,1; sort unit output for input 0x09 with last is {09,ff,ff,ff} three cycles later.
